// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: widths, special
// register numbers and writeback requester indices.
package regfile_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;
  localparam int IDX_W  = 3;

  localparam int unsigned ZERO_REG      = 0;
  localparam int unsigned STACK_PTR_REG = 14;
  localparam int unsigned OUTPUT_REG    = 15;
  localparam logic [23:0] SP_RESET      = 24'd964;

  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_LOAD = 1;
  localparam int unsigned REQ_SP   = 2;

  // Successor of idx in a ring of n slots.
  function automatic int unsigned nextIdx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Rotating picker: first set request at or after ptr, wrapping to 0.
// A pointer tied to zero turns it into a fixed-priority picker.
module rr_pick
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    int unsigned cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: grants one requester per cycle into a single commit
// stage feeding the register-file write port, with read-port forwarding.
// Define REGFILE_WB_ARB_RR_EN for round-robin; otherwise fixed priority (req 0 first).
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic [ADDR_W-1:0]         chk_addr_a,
  input  logic [ADDR_W-1:0]         chk_addr_b,
  output logic                      fwd_hit_a,
  output logic                      fwd_hit_b,
  output logic [DATA_W-1:0]         fwd_data,
  output logic [2:0]                grant_id
);

  import regfile_pkg::*;

  logic [IDX_W-1:0]   rrPtr;
  logic [NUM_REQ-1:0] pickGrant;
  logic [IDX_W-1:0]   pickIdx;
  logic               pickFound;
  logic               accept;
  logic [ADDR_W-1:0]  selAddr;
  logic [DATA_W-1:0]  selData;
  logic [ADDR_W-1:0]  commitAddr;
  logic [DATA_W-1:0]  commitData;
  logic [IDX_W-1:0]   commitId;

  rr_pick #(.NUM_REQ(NUM_REQ)) picker (
    .req   (req_valid),
    .ptr   (rrPtr),
    .grant (pickGrant),
    .idx   (pickIdx),
    .found (pickFound)
  );

  assign accept    = pickFound && !rst;
  assign req_ready = rst ? '0 : pickGrant;

`ifdef REGFILE_WB_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)
      rrPtr <= '0;
    else if (accept)
      rrPtr <= IDX_W'(nextIdx(int unsigned'(pickIdx), int unsigned'(NUM_REQ)));
  end
`else
  assign rrPtr = '0;
`endif

  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pickGrant[i]) begin
        selAddr = req_addr[i*ADDR_W +: ADDR_W];
        selData = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage drains every cycle; an idle cycle loads address 0 and keeps the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      commitAddr <= '0;
      commitData <= '0;
      commitId   <= '0;
    end else if (accept) begin
      commitAddr <= selAddr;
      commitData <= selData;
      commitId   <= pickIdx;
    end else begin
      commitAddr <= '0;
    end
  end

  // Masking with rst drops a write already in the stage during the reset cycle.
  assign wr_addr  = rst ? '0 : commitAddr;
  assign wr_data  = commitData;
  assign fwd_data = commitData;
  assign grant_id = 3'(commitId);

  assign fwd_hit_a = (wr_addr != ADDR_W'(ZERO_REG)) && (wr_addr == chk_addr_a);
  assign fwd_hit_b = (wr_addr != ADDR_W'(ZERO_REG)) && (wr_addr == chk_addr_b);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter; reference model tracks the
// expected commit stage and arbitration pointer from the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 24;
`ifdef REGFILE_WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [AW-1:0] wr_addr, chk_addr_a, chk_addr_b;
  logic [DW-1:0] wr_data, fwd_data;
  logic          fwd_hit_a, fwd_hit_b;
  logic [2:0]    grant_id;

  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  int checks = 0;
  int errors = 0;

  int            mPtr, mId, lastGrant;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mData;
  int            waitCnt [N];

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .chk_addr_a (chk_addr_a),
    .chk_addr_b (chk_addr_b),
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_data   (fwd_data),
    .grant_id   (grant_id)
  );

  // Requester protocol: a waiting request stays valid with stable payload.
  logic          protoOn = 1'b0, protoArmed = 1'b0;
  logic [N-1:0]  pV, pR;
  logic [N*AW-1:0] pA;
  logic [N*DW-1:0] pD;
  always @(posedge clk) begin
    if (protoArmed && protoOn && !rst)
      for (int i = 0; i < N; i++)
        if (pV[i] && !pR[i])
          assert (req_valid[i] && req_addr[i*AW +: AW] == pA[i*AW +: AW] &&
                  req_data[i*DW +: DW] == pD[i*DW +: DW])
            else $error("protocol violated by requester %0d", i);
    protoArmed <= protoOn;
    pV <= req_valid;
    pR <= req_ready;
    pA <= req_addr;
    pD <= req_data;
  end

  function automatic int pickModel(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] expReady();
    logic [N-1:0] r;
    int g;
    r = '0;
    if (!rst) begin
      g = pickModel(req_valid, RR ? mPtr : 0);
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  // Advance one clock and update the model with what the edge should commit.
  task automatic tick();
    int g;
    @(posedge clk);
    g = pickModel(req_valid, RR ? mPtr : 0);
    lastGrant = -1;
    if (rst) begin
      mAddr = '0; mData = '0; mId = 0; mPtr = 0;
    end else if (g >= 0) begin
      mAddr = a[g]; mData = d[g]; mId = g; mPtr = (g + 1) % N; lastGrant = g;
    end else begin
      mAddr = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin a[i] = AW'(i + 4); d[i] = DW'($urandom); end
    chk_addr_a = a[0];
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
      checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
      tick();
      checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr_post: got %0d expected 0", wr_addr); end
      checks++; if (wr_data !== 24'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
      checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
      checks++; if (fwd_hit_a !== 1'b0) begin errors++; $display("FAIL reset_fwd_a: got %b expected 0", fwd_hit_a); end
    end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_first_grant: got %b expected 001", req_ready); end
    tick();
    checks++; if (wr_addr !== a[0]) begin errors++; $display("FAIL reset_first_commit: got %0d expected %0d", wr_addr, a[0]); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_first_id: got %0d expected 0", grant_id); end
    req_valid = '0;
    #1; tick();
  endtask

  task automatic test_single();
    req_valid = 3'b010; a[1] = 4'd5; d[1] = 24'h00ABCD;
    chk_addr_a = 4'd5; chk_addr_b = 4'd6;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b expected 010", req_ready); end
    tick();
    checks++; if (wr_addr !== 4'd5) begin errors++; $display("FAIL single_wr_addr: got %0d expected 5", wr_addr); end
    checks++; if (wr_data !== 24'h00ABCD) begin errors++; $display("FAIL single_wr_data: got %h expected 00abcd", wr_data); end
    checks++; if (fwd_hit_a !== 1'b1) begin errors++; $display("FAIL single_fwd_a: got %b expected 1", fwd_hit_a); end
    checks++; if (fwd_hit_b !== 1'b0) begin errors++; $display("FAIL single_fwd_b: got %b expected 0", fwd_hit_b); end
    checks++; if (fwd_data !== 24'h00ABCD) begin errors++; $display("FAIL single_fwd_data: got %h expected 00abcd", fwd_data); end
    req_valid = '0;
    #1; tick();
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL single_drain: got %0d expected 0", wr_addr); end
    checks++; if (fwd_hit_a !== 1'b0) begin errors++; $display("FAIL single_fwd_drain: got %b expected 0", fwd_hit_a); end
    checks++; if (wr_data !== 24'h00ABCD) begin errors++; $display("FAIL single_data_hold: got %h expected 00abcd", wr_data); end
  endtask

  task automatic test_contention();
    int exp [6];
    logic [N-1:0] e;
    rst = 1'b1; req_valid = '0;
    #1; tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin a[i] = AW'(i + 1); d[i] = DW'($urandom); end
    req_valid = '1;
    for (int k = 0; k < 6; k++) exp[k] = RR ? (k % N) : 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      e = '0; e[exp[k]] = 1'b1;
      checks++; if (req_ready !== e) begin errors++; $display("FAIL contention_ready[%0d]: got %b expected %b", k, req_ready, e); end
      tick();
      checks++; if (grant_id !== 3'(exp[k])) begin errors++; $display("FAIL contention_id[%0d]: got %0d expected %0d", k, grant_id, exp[k]); end
      checks++; if (wr_addr !== AW'(exp[k] + 1)) begin errors++; $display("FAIL contention_addr[%0d]: got %0d expected %0d", k, wr_addr, exp[k] + 1); end
    end
    req_valid = '0;
    #1; tick();
  endtask

  task automatic test_same_reg();
    req_valid = 3'b001; a[0] = 4'd3; d[0] = 24'd1;
    #1; tick();
    checks++; if (wr_addr !== 4'd3 || wr_data !== 24'd1) begin errors++; $display("FAIL same_reg_first: got %0d/%0d expected 3/1", wr_addr, wr_data); end
    req_valid = 3'b100; a[2] = 4'd3; d[2] = 24'd2;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL same_reg_ready: got %b expected 100", req_ready); end
    tick();
    checks++; if (wr_addr !== 4'd3 || wr_data !== 24'd2) begin errors++; $display("FAIL same_reg_second: got %0d/%0d expected 3/2", wr_addr, wr_data); end
    req_valid = '0;
    #1; tick();
  endtask

  task automatic test_zero_addr();
    req_valid = 3'b010; a[1] = 4'd9; d[1] = DW'($urandom);
    #1; tick();
    req_valid = 3'b100; a[2] = 4'd0; d[2] = 24'hFFFFFF;
    chk_addr_a = 4'd0; chk_addr_b = 4'd0;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL zero_ready: got %b expected 100", req_ready); end
    tick();
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL zero_wr_addr: got %0d expected 0", wr_addr); end
    checks++; if (fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0) begin errors++; $display("FAIL zero_fwd: got %b%b expected 00", fwd_hit_a, fwd_hit_b); end
    checks++; if (grant_id !== 3'd2) begin errors++; $display("FAIL zero_id: got %0d expected 2", grant_id); end
    req_valid = '1;
    for (int i = 0; i < N; i++) a[i] = AW'(i + 7);
    #1;
    checks++; if (req_ready !== expReady()) begin errors++; $display("FAIL zero_ptr_advance: got %b expected %b", req_ready, expReady()); end
    tick();
    req_valid = '0;
    #1; tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 3'b001; a[0] = 4'd14; d[0] = 24'd7;
    #1; tick();
    rst = 1'b1; req_valid = '0; chk_addr_a = 4'd14;
    #1;
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL mid_reset_wr_addr: got %0d expected 0", wr_addr); end
    checks++; if (fwd_hit_a !== 1'b0) begin errors++; $display("FAIL mid_reset_fwd: got %b expected 0", fwd_hit_a); end
    tick();
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL mid_reset_after: got %0d expected 0", wr_addr); end
    rst = 1'b0;
    #1; tick();
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL mid_reset_idle: got %0d expected 0", wr_addr); end
  endtask

  task automatic test_random();
    logic expHitA, expHitB;
    rst = 1'b1; req_valid = '0;
    #1; tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) waitCnt[i] = 0;
    protoOn = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (!(req_valid[i] && lastGrant != i)) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          a[i] = AW'($urandom_range(0, 15));
          d[i] = DW'($urandom);
        end
      chk_addr_a = ($urandom_range(0, 2) == 0) ? a[$urandom_range(0, N - 1)] : AW'($urandom_range(0, 15));
      chk_addr_b = AW'($urandom_range(0, 15));
      #1;
      checks++; if (req_ready !== expReady()) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, expReady()); end
      tick();
      expHitA = (mAddr != 0) && (mAddr == chk_addr_a);
      expHitB = (mAddr != 0) && (mAddr == chk_addr_b);
      checks++; if (wr_addr !== mAddr) begin errors++; $display("FAIL rand_wr_addr[%0d]: got %0d expected %0d", c, wr_addr, mAddr); end
      checks++; if (wr_data !== mData) begin errors++; $display("FAIL rand_wr_data[%0d]: got %h expected %h", c, wr_data, mData); end
      checks++; if (grant_id !== 3'(mId)) begin errors++; $display("FAIL rand_grant_id[%0d]: got %0d expected %0d", c, grant_id, mId); end
      checks++; if (fwd_hit_a !== expHitA || fwd_hit_b !== expHitB) begin errors++; $display("FAIL rand_fwd[%0d]: got %b%b expected %b%b", c, fwd_hit_a, fwd_hit_b, expHitA, expHitB); end
      if (expHitA) begin
        checks++; if (fwd_data !== mData) begin errors++; $display("FAIL rand_fwd_data[%0d]: got %h expected %h", c, fwd_data, mData); end
      end
      for (int i = 0; i < N; i++) waitCnt[i] = (req_valid[i] && lastGrant != i) ? waitCnt[i] + 1 : 0;
`ifdef REGFILE_WB_ARB_RR_EN
      for (int i = 0; i < N; i++) begin
        checks++; if (waitCnt[i] > N - 1) begin errors++; $display("FAIL rand_starve[%0d]: requester %0d waited %0d expected <= %0d", c, i, waitCnt[i], N - 1); end
      end
`endif
    end
    protoOn = 1'b0;
    req_valid = '0;
    #1; tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    chk_addr_a = '0;
    chk_addr_b = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    mPtr = 0; mId = 0; mAddr = '0; mData = '0; lastGrant = -1;
    tick();
    test_reset();
    test_single();
    test_contention();
    test_same_reg();
    test_zero_addr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (4-bit address, 24-bit data) among NUM_REQ writeback requesters: ALU, load unit, stack-pointer unit. Grants at most one request per cycle and holds it in a one-entry commit stage that drives the register file's write address/data. Also provides forwarding of the in-flight (not yet committed) write to the two read ports.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 24, register data width
ADDR_W, 4, register address width; address 0 = no write

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester write request
req_addr  in  NUM_REQ*ADDR_W  packed destination addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed write data, same packing
req_ready  out  NUM_REQ  one-hot grant; transfer when valid&ready
wr_addr  out  ADDR_W  to register-file write address; 0 = idle
wr_data  out  DATA_W  to register-file write data
chk_addr_a  in  ADDR_W  read port A address being read this cycle
chk_addr_b  in  ADDR_W  read port B address
fwd_hit_a  out  1  commit stage holds pending write to chk_addr_a
fwd_hit_b  out  1  same for port B
fwd_data  out  DATA_W  data of commit stage (valid when a hit is set)
grant_id  out  3  index of requester owning the commit stage (debug)

Behaviour:
- Reset: wr_addr=0, wr_data=0, grant_id=0, req_ready=0, fwd_hit_a/b=0, RR pointer=0. req_ready is forced to 0 in the reset cycle; any in-flight commit-stage write is dropped (never reaches the register file).
- req_ready is combinational from req_valid and the RR pointer; exactly one bit set when any req_valid=1, else all 0. Never depends on req_addr/req_data.
- Accept at edge t (valid&ready): commit stage loads addr/data/id; wr_addr/wr_data valid during cycle t+1; register file captures at edge t+1. Latency request->architectural state = 2 edges.
- Commit stage drains every cycle (register file never stalls); if no grant, it loads wr_addr=0 (wr_data holds its previous value).
- Requests with addr 0 are accepted normally (ready pulses, pointer advances) but produce wr_addr=0: discarded write.
- Forwarding: fwd_hit_x = (wr_addr!=0) && (wr_addr==chk_addr_x). chk_addr 0 never hits.
- Arbitration (RR): search starts at pointer p, wrapping NUM_REQ-1 -> 0; after a grant to i, p <= (i+1) mod NUM_REQ. No grant: p unchanged.
- Two requesters targeting the same register in consecutive cycles: commit order = grant order; later write wins.
- Requester holding valid while not granted must keep addr/data stable (protocol rule; bench asserts it).
- Steady state: any continuously-valid requester is granted within NUM_REQ cycles.

Optional Feature:
Macro REGFILE_WB_ARB_RR_EN. Defined: round-robin as above. Undefined: fixed priority, requester 0 highest; pointer register removed; starvation allowed.

Decomposition:
- Package regfile_pkg: DATA_W, ADDR_W, ZERO_REG=0, STACK_PTR_REG=14, OUTPUT_REG=15, SP_RESET=24'd964, requester index constants (REQ_ALU=0, REQ_LOAD=1, REQ_SP=2).
- One sub-module: rr_pick (NUM_REQ-wide request vector + pointer -> one-hot grant + encoded index); fixed-priority mode = pointer tied to 0.

Test Plan:
- Reset: hold rst 2 cycles with all req_valid=1 -> req_ready=0, wr_addr=0 throughout; first grant to requester 0 on the cycle after rst drops.
- Single request: req 1 addr 5 data 24'h00ABCD at edge t -> wr_addr=5, wr_data=24'h00ABCD during t+1, 0 at t+2; fwd_hit_a=1 when chk_addr_a=5 during t+1.
- Contention (RR_EN): all three valid 6 cycles -> grant sequence 0,1,2,0,1,2; without macro -> 0,0,0,0,0,0.
- Same-register order: req 0 writes r3=1 then req 2 writes r3=2 -> wr_addr=3 two consecutive cycles, data 1 then 2.
- Zero address: req 2 addr 0 data 24'hFFFFFF -> req_ready pulses, wr_addr stays 0, no fwd hit for chk_addr 0.
- Reset mid-operation: grant r14=7 at edge t, rst=1 in cycle t+1 -> wr_addr=0 in t+1 and t+2; no write to r14 occurs.
